// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive blocks: FSM state
// encoding, parity mode selectors and the cell-counter width helper.
package uart_pkg;

  // Frame FSM states shared by the transmitter and the future receiver.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } txState_e;

  // Parity selector values for the PARITY_MODE parameter.
  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // Width of a counter that runs 0..clksPerBit-1, never narrower than one bit.
  function automatic int unsigned cellCountWidth(input int unsigned clksPerBit);
    return (clksPerBit < 2) ? 1 : $clog2(clksPerBit);
  endfunction

endpackage

// File: rtl/uart_tx_frame_timer.sv
// Bit-cell timer: counts clock cycles inside one serial bit cell and raises
// a strobe on the last cycle of each cell. Shared with the receive side.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic clock,
  input  logic reset_n,
  input  logic run_i,
  output logic tick_o
);

  localparam int unsigned CW = cellCountWidth(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q, count_d;

  // Next count: parked at zero while stopped, otherwise wrap on the last cycle.
  always_comb begin
    count_d = count_q;
    if (!run_i) begin
      count_d = '0;
    end else if (count_q == LAST_COUNT) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o = run_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one-entry holding register feeding a frame shifter so
// queued characters leave back-to-back. Start, data (LSB first), optional
// parity and 1 or 2 stop cells, each CLKS_PER_BIT clocks long.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 has_data,
  input  logic [DATA_BITS-1:0] data_to_send,
  output logic                 tx_ready,
  output logic                 is_transmitting,
  output logic                 sending_bit,
  output logic                 transmission_done
);

  localparam bit         HAS_PARITY = (PARITY_MODE != PARITY_NONE);
  localparam logic       PAR_INVERT = (PARITY_MODE == PARITY_ODD);
  localparam logic [3:0] LAST_BIT   = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP  = 1'(STOP_BITS - 1);

  txState_e             state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 holdValid_q, holdValid_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bitIdx_q, bitIdx_d;
  logic                 stopIdx_q, stopIdx_d;
  logic                 parity_q, parity_d;
  logic                 line_q, line_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 drain;
  logic                 cellTick;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .run_i  (state_q != IDLE),
    .tick_o (cellTick)
  );

  // The holding register may refill on the same edge it drains into the shifter.
  assign tx_ready = !holdValid_q || drain;

  // Frame sequencing; loads the shifter and parity from the holding register.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitIdx_d  = bitIdx_q;
    stopIdx_d = stopIdx_q;
    parity_d  = parity_q;
    done_d    = 1'b0;
    drain     = 1'b0;
    case (state_q)
      IDLE: begin
        if (holdValid_q) begin
          drain    = 1'b1;
          shift_d  = hold_q;
          parity_d = (^hold_q) ^ PAR_INVERT;
          state_d  = START;
        end
      end
      START: begin
        if (cellTick) begin
          bitIdx_d = '0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (cellTick) begin
          shift_d = shift_q >> 1;
          if (bitIdx_q == LAST_BIT) begin
            stopIdx_d = 1'b0;
            state_d   = HAS_PARITY ? PARITY : STOP;
          end else begin
            bitIdx_d = bitIdx_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (cellTick) begin
          stopIdx_d = 1'b0;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (cellTick) begin
          if (stopIdx_q == LAST_STOP) begin
            done_d = 1'b1;
            if (holdValid_q) begin
              drain    = 1'b1;
              shift_d  = hold_q;
              parity_d = (^hold_q) ^ PAR_INVERT;
              state_d  = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stopIdx_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register: capture on accept, empty when drained without a refill.
  always_comb begin
    hold_d      = hold_q;
    holdValid_d = holdValid_q;
    if (has_data && tx_ready) begin
      hold_d      = data_to_send;
      holdValid_d = 1'b1;
    end else if (drain) begin
      holdValid_d = 1'b0;
    end
  end

  // Registered line level and busy flag decoded from the upcoming state.
  always_comb begin
    line_d = 1'b1;
    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = shift_d[0];
      PARITY:  line_d = parity_d;
      default: line_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      holdValid_q <= 1'b0;
      shift_q     <= '0;
      bitIdx_q    <= '0;
      stopIdx_q   <= 1'b0;
      parity_q    <= 1'b0;
      line_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      holdValid_q <= holdValid_d;
      shift_q     <= shift_d;
      bitIdx_q    <= bitIdx_d;
      stopIdx_q   <= stopIdx_d;
      parity_q    <= parity_d;
      line_q      <= line_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign sending_bit       = line_q;
  assign is_transmitting   = busy_q;
  assign transmission_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three configurations (8N1/CPB4, 7E2/CPB3,
// 5O1/CPB2) share one stimulus stream and are compared every cycle against
// a frame-level reference model built from the serial framing rules.
module tb_uart_tx_frame;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       hasData;
  logic [7:0] dataIn;
  logic [2:0] txReady, busy, line, done;

  int compareCount  = 0;
  int mismatchCount = 0;
  int cycle         = 0;

  // Reference model state, one slot per DUT.
  bit holdFull [3];
  int holdVal  [3];
  bit active   [3];
  int pos      [3];
  int cells    [3];
  bit frame    [3][16];
  bit expDone  [3];

  always #5 clock = ~clock;

  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
    .clock(clock), .reset_n(reset_n), .has_data(hasData), .data_to_send(dataIn[7:0]),
    .tx_ready(txReady[0]), .is_transmitting(busy[0]), .sending_bit(line[0]),
    .transmission_done(done[0]));

  uart_tx_frame #(.CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) dut1 (
    .clock(clock), .reset_n(reset_n), .has_data(hasData), .data_to_send(dataIn[6:0]),
    .tx_ready(txReady[1]), .is_transmitting(busy[1]), .sending_bit(line[1]),
    .transmission_done(done[1]));

  uart_tx_frame #(.CLKS_PER_BIT(2), .DATA_BITS(5), .PARITY_MODE(1), .STOP_BITS(1)) dut2 (
    .clock(clock), .reset_n(reset_n), .has_data(hasData), .data_to_send(dataIn[4:0]),
    .tx_ready(txReady[2]), .is_transmitting(busy[2]), .sending_bit(line[2]),
    .transmission_done(done[2]));

  function automatic int cpbOf(input int d);
    case (d)
      0: return 4;
      1: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int dbOf(input int d);
    case (d)
      0: return 8;
      1: return 7;
      default: return 5;
    endcase
  endfunction

  function automatic int pmOf(input int d);
    case (d)
      0: return 0;
      1: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int sbOf(input int d);
    case (d)
      1: return 2;
      default: return 1;
    endcase
  endfunction

  // Cell list of one frame: start, data LSB first, optional parity, stops.
  task automatic buildFrame(input int d, input int v);
    int n;
    int ones;
    n = 0;
    ones = 0;
    frame[d][n] = 1'b0;
    n++;
    for (int i = 0; i < dbOf(d); i++) begin
      frame[d][n] = bit'((v >> i) & 1);
      ones += (v >> i) & 1;
      n++;
    end
    if (pmOf(d) != 0) begin
      frame[d][n] = (pmOf(d) == 2) ? bit'(ones % 2) : bit'(1 - (ones % 2));
      n++;
    end
    for (int s = 0; s < sbOf(d); s++) begin
      frame[d][n] = 1'b1;
      n++;
    end
    cells[d] = n;
  endtask

  function automatic bit modelFinishing(input int d);
    return active[d] && (pos[d] == cells[d] * cpbOf(d) - 1);
  endfunction

  function automatic bit modelReady(input int d);
    return !holdFull[d] || !active[d] || modelFinishing(d);
  endfunction

  function automatic bit modelLine(input int d);
    return active[d] ? frame[d][pos[d] / cpbOf(d)] : 1'b1;
  endfunction

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic modelStep(input int d);
    bit finishing;
    bit draining;
    bit accept;
    if (!reset_n) begin
      holdFull[d] = 1'b0;
      active[d]   = 1'b0;
      pos[d]      = 0;
      expDone[d]  = 1'b0;
      return;
    end
    finishing = modelFinishing(d);
    draining  = holdFull[d] && (!active[d] || finishing);
    accept    = hasData && modelReady(d);
    expDone[d] = finishing;
    if (active[d]) begin
      pos[d]++;
      if (finishing) active[d] = 1'b0;
    end
    if (draining) begin
      buildFrame(d, holdVal[d]);
      active[d] = 1'b1;
      pos[d]    = 0;
    end
    if (accept) begin
      holdFull[d] = 1'b1;
      holdVal[d]  = int'(dataIn) & ((1 << dbOf(d)) - 1);
    end else if (draining) begin
      holdFull[d] = 1'b0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, step the model at the edge, compare mid-cycle.
  task automatic applyStimulus(input logic h, input logic [7:0] v, input logic r);
    hasData = h;
    dataIn  = v;
    reset_n = r;
    @(posedge clock);
    for (int d = 0; d < 3; d++) modelStep(d);
    @(negedge clock);
    cycle++;
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("d%0d.tx_ready@%0d", d, cycle), txReady[d], modelReady(d));
      checkOutput($sformatf("d%0d.sending_bit@%0d", d, cycle), line[d], modelLine(d));
      checkOutput($sformatf("d%0d.is_transmitting@%0d", d, cycle), busy[d], active[d]);
      checkOutput($sformatf("d%0d.transmission_done@%0d", d, cycle), done[d], expDone[d]);
    end
  endtask

  task automatic idleCycles(input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, v, 1'b1);
  endtask

  initial begin
    hasData = 1'b0;
    dataIn  = 8'h00;
    reset_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);

    // Single frame 0xA5, then garbage on the data bus.
    applyStimulus(1'b1, 8'hA5, 1'b1);
    idleCycles(50, 8'hFF);

    // 0x55: four ones in the 7-bit view gives even parity 0.
    applyStimulus(1'b1, 8'h55, 1'b1);
    idleCycles(50, 8'h00);

    // Accepted data must not follow later bus changes.
    applyStimulus(1'b1, 8'h3C, 1'b1);
    idleCycles(50, 8'h00);

    // Back-to-back: second byte queued while the first is in its data cells.
    applyStimulus(1'b1, 8'h01, 1'b1);
    idleCycles(12, 8'h00);
    applyStimulus(1'b1, 8'hFF, 1'b1);
    idleCycles(100, 8'h00);

    // Reset during data bit 3 of the 8N1 frame, then a clean frame.
    applyStimulus(1'b1, 8'h96, 1'b1);
    idleCycles(17, 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b0);
    idleCycles(3, 8'h00);
    applyStimulus(1'b1, 8'h5A, 1'b1);
    idleCycles(50, 8'h00);

    // Flow control: has_data held high across three distinct bytes.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 45; i++) applyStimulus(1'b1, 8'(8'h11 * (k + 1)), 1'b1);
    end
    idleCycles(100, 8'h00);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 9) < 6, 8'($urandom_range(0, 255)),
                    $urandom_range(0, 299) != 0);
    end
    idleCycles(60, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
